tdp_ram_pipelined: RTL and testbench

Generic true dual-port RAM, inferred from behavioural RTL with no vendor macro. It generalises the team's fixed-width dual-port RAM wrappers with:
- per-byte write enables;
- a parametrised read pipeline;
- selectable write mode;
- deterministic cross-port collision handling;
- read-valid tracking.

It serves as the backing store for caches, TLB and branch-predictor tables, where both ports read and write in the same cycle.

---
 rtl/tdp_ram_pipelined.sv | 155 +++++++++++++++
 tb/tb_tdp_ram_pipelined.sv | 299 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/tdp_ram_pipelined.sv
// True dual-port RAM with per-byte write enables, a per-port read pipeline and fixed collision rules.
// Latency: READ_LATENCY cycles (1..4) from the access edge to dout/rvalid on the same port.
// Backpressure: none; every access is accepted, and responses leave the pipeline with no stall.
//
// Ports (port B mirrors port A):
//   clk, rst               : clock and asynchronous active-high reset
//   ena, wea, addra, dina  : access enable, byte write enables, address, write data
//   douta, rvalid_a        : response data (held between responses) and one-cycle response strobe
module tdp_ram_pipelined #(
  parameter int DATA_WIDTH        = 32,
  parameter int BYTE_WIDTH        = 8,
  parameter int DEPTH             = 128,
  parameter int READ_LATENCY      = 1,
  parameter int WRITE_MODE        = 0,
  parameter int COLLISION_FORWARD = 1,
  localparam int NB               = DATA_WIDTH / BYTE_WIDTH,
  localparam int AW               = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  ena,
  input  logic [NB-1:0]         wea,
  input  logic [AW-1:0]         addra,
  input  logic [DATA_WIDTH-1:0] dina,
  output logic [DATA_WIDTH-1:0] douta,
  output logic                  rvalid_a,
  input  logic                  enb,
  input  logic [NB-1:0]         web,
  input  logic [AW-1:0]         addrb,
  input  logic [DATA_WIDTH-1:0] dinb,
  output logic [DATA_WIDTH-1:0] doutb,
  output logic                  rvalid_b
);

  // Elaboration-time parameter checks
  generate
    if (READ_LATENCY < 1 || READ_LATENCY > 4) begin : g_bad_latency
      $error("tdp_ram_pipelined: READ_LATENCY must be in 1..4");
    end
    if (DATA_WIDTH % BYTE_WIDTH != 0) begin : g_bad_width
      $error("tdp_ram_pipelined: DATA_WIDTH must be a multiple of BYTE_WIDTH");
    end
    if (WRITE_MODE < 0 || WRITE_MODE > 2) begin : g_bad_mode
      $error("tdp_ram_pipelined: WRITE_MODE must be 0, 1 or 2");
    end
  endgenerate

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  // Address range qualification; only a non-power-of-two depth can see stray addresses
  logic inr_a, inr_b;
  generate
    if (DEPTH == (1 << AW)) begin : g_pow2
      assign inr_a = 1'b1;
      assign inr_b = 1'b1;
    end else begin : g_npow2
      assign inr_a = (32'(addra) < 32'(DEPTH));
      assign inr_b = (32'(addrb) < 32'(DEPTH));
    end
  endgenerate

  function automatic logic [DATA_WIDTH-1:0] merge(input logic [DATA_WIDTH-1:0] old,
                                                  input logic [DATA_WIDTH-1:0] din,
                                                  input logic [NB-1:0]         be);
    merge = old;
    for (int i = 0; i < NB; i++) begin
      if (be[i]) merge[i*BYTE_WIDTH +: BYTE_WIDTH] = din[i*BYTE_WIDTH +: BYTE_WIDTH];
    end
  endfunction

  // Accesses presented while reset is high are ignored
  logic rd_a, wr_a, rd_b, wr_b, same;
  assign rd_a = ena && !rst && (wea == '0);
  assign wr_a = ena && !rst && (wea != '0);
  assign rd_b = enb && !rst && (web == '0);
  assign wr_b = enb && !rst && (web != '0);
  assign same = (addra == addrb);

  logic [DATA_WIDTH-1:0] old_a, old_b;
  assign old_a = inr_a ? mem[addra] : '0;
  assign old_b = inr_b ? mem[addrb] : '0;

  // Word each address holds after this edge. B is applied before A so that
  // port A owns any byte both ports enable on a shared address.
  logic [DATA_WIDTH-1:0] fin_a, fin_b;
  always_comb begin
    fin_a = old_a;
    if (wr_b && same) fin_a = merge(fin_a, dinb, web);
    if (wr_a)         fin_a = merge(fin_a, dina, wea);
    fin_b = old_b;
    if (wr_b)         fin_b = merge(fin_b, dinb, web);
    if (wr_a && same) fin_b = merge(fin_b, dina, wea);
  end

  // Response generated on this edge for each port
  logic                  rsp_vld_a, rsp_vld_b;
  logic [DATA_WIDTH-1:0] rsp_dat_a, rsp_dat_b;
  always_comb begin
    rsp_vld_a = rd_a || (wr_a && WRITE_MODE != 2);
    rsp_vld_b = rd_b || (wr_b && WRITE_MODE != 2);
    rsp_dat_a = '0;
    rsp_dat_b = '0;
    if (inr_a) begin
      if (rd_a)                 rsp_dat_a = (COLLISION_FORWARD != 0 && wr_b && same) ? fin_a : old_a;
      else if (WRITE_MODE == 1) rsp_dat_a = fin_a;
      else                      rsp_dat_a = old_a;
    end
    if (inr_b) begin
      if (rd_b)                 rsp_dat_b = (COLLISION_FORWARD != 0 && wr_a && same) ? fin_b : old_b;
      else if (WRITE_MODE == 1) rsp_dat_b = fin_b;
      else                      rsp_dat_b = old_b;
    end
  end

  // Array storage has no reset. On a shared-address double write both ports
  // carry the same merged word, so only port A performs the store.
  always_ff @(posedge clk) begin
    if (wr_a && inr_a) mem[addra] <= fin_a;
    if (wr_b && inr_b && !(wr_a && same)) mem[addrb] <= fin_b;
  end

  // Read pipelines. Valid bits shift every cycle; a data stage only loads
  // when a valid response reaches it, so dout holds between responses.
  logic [DATA_WIDTH-1:0] pa_dat [READ_LATENCY];
  logic [DATA_WIDTH-1:0] pb_dat [READ_LATENCY];
  logic [READ_LATENCY-1:0] pa_vld, pb_vld;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pa_vld <= '0;
      pb_vld <= '0;
      for (int i = 0; i < READ_LATENCY; i++) begin
        pa_dat[i] <= '0;
        pb_dat[i] <= '0;
      end
    end else begin
      pa_vld[0] <= rsp_vld_a;
      pb_vld[0] <= rsp_vld_b;
      if (rsp_vld_a) pa_dat[0] <= rsp_dat_a;
      if (rsp_vld_b) pb_dat[0] <= rsp_dat_b;
      for (int i = 1; i < READ_LATENCY; i++) begin
        pa_vld[i] <= pa_vld[i-1];
        pb_vld[i] <= pb_vld[i-1];
        if (pa_vld[i-1]) pa_dat[i] <= pa_dat[i-1];
        if (pb_vld[i-1]) pb_dat[i] <= pb_dat[i-1];
      end
    end
  end

  assign douta    = pa_dat[READ_LATENCY-1];
  assign rvalid_a = pa_vld[READ_LATENCY-1];
  assign doutb    = pb_dat[READ_LATENCY-1];
  assign rvalid_b = pb_vld[READ_LATENCY-1];

endmodule

// File: tb/tb_tdp_ram_pipelined.sv
module tb_tdp_ram_pipelined;

  localparam int NK = 4;  // number of DUT configurations driven in parallel

  function automatic int rl_of(input int k);
    case (k)
      0: return 2;
      1: return 1;
      2: return 3;
      default: return 4;
    endcase
  endfunction
  function automatic int wm_of(input int k);
    case (k)
      0: return 0;
      1: return 1;
      2: return 2;
      default: return 0;
    endcase
  endfunction
  function automatic int cf_of(input int k);
    case (k)
      0: return 1;
      1: return 0;
      2: return 1;
      default: return 0;
    endcase
  endfunction

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        ena = 1'b0, enb = 1'b0;
  logic [3:0]  wea = 4'h0, web = 4'h0;
  logic [6:0]  addra = 7'd0, addrb = 7'd0;
  logic [31:0] dina = 32'h0, dinb = 32'h0;
  logic [NK*2-1:0][31:0] dout_w;
  logic [NK*2-1:0]       rv_w;

  always #5 clk = ~clk;

  for (genvar g = 0; g < NK; g++) begin : g_dut
    tdp_ram_pipelined #(
      .DATA_WIDTH(32), .BYTE_WIDTH(8), .DEPTH(128),
      .READ_LATENCY(rl_of(g)), .WRITE_MODE(wm_of(g)), .COLLISION_FORWARD(cf_of(g))
    ) u_dut (
      .clk(clk), .rst(rst),
      .ena(ena), .wea(wea), .addra(addra), .dina(dina),
      .douta(dout_w[2*g]), .rvalid_a(rv_w[2*g]),
      .enb(enb), .web(web), .addrb(addrb), .dinb(dinb),
      .doutb(dout_w[2*g+1]), .rvalid_b(rv_w[2*g+1])
    );
  end

  int tests = 0;
  int fails = 0;
  int edge_no = 0;
  bit chk_on = 1'b0;

  // Reference model: plain memory image plus a per-output schedule of
  // responses keyed by the edge number on which they must appear.
  logic [31:0] mem [128];
  logic        slot_v [NK*2][8];
  logic [31:0] slot_d [NK*2][8];
  logic [31:0] held   [NK*2];

  task automatic chk(input string name, input logic [32:0] act, input logic [32:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] bytes_in(input logic [31:0] old, input logic [31:0] din,
                                           input logic [3:0] be);
    logic [31:0] r;
    r = old;
    for (int i = 0; i < 4; i++) if (be[i]) r[8*i +: 8] = din[8*i +: 8];
    return r;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < NK*2; i++) begin
      held[i] = 32'h0;
      for (int s = 0; s < 8; s++) slot_v[i][s] = 1'b0;
    end
  endtask

  task automatic issue(input int idx, input logic [31:0] d);
    int due;
    due = edge_no + rl_of(idx / 2) - 1;
    slot_v[idx][due % 8] = 1'b1;
    slot_d[idx][due % 8] = d;
  endtask

  task automatic model_edge();
    logic [31:0] old_a, old_b, new_a, new_b;
    logic ra, rb, wa, wb;
    edge_no++;
    if (rst) return;
    ra = ena && (wea == 4'h0);
    wa = ena && (wea != 4'h0);
    rb = enb && (web == 4'h0);
    wb = enb && (web != 4'h0);
    old_a = mem[addra];
    old_b = mem[addrb];
    if (wb) mem[addrb] = bytes_in(mem[addrb], dinb, web);
    if (wa) mem[addra] = bytes_in(mem[addra], dina, wea);  // A last: A wins shared bytes
    new_a = mem[addra];
    new_b = mem[addrb];
    for (int k = 0; k < NK; k++) begin
      if (ra)                     issue(2*k, (cf_of(k) == 1) ? new_a : old_a);
      else if (wa && wm_of(k) != 2) issue(2*k, (wm_of(k) == 1) ? new_a : old_a);
      if (rb)                     issue(2*k+1, (cf_of(k) == 1) ? new_b : old_b);
      else if (wb && wm_of(k) != 2) issue(2*k+1, (wm_of(k) == 1) ? new_b : old_b);
    end
  endtask

  task automatic check_outputs();
    int s;
    logic ev;
    s = edge_no % 8;
    for (int i = 0; i < NK*2; i++) begin
      ev = slot_v[i][s];
      if (ev) held[i] = slot_d[i][s];
      slot_v[i][s] = 1'b0;
      if (chk_on)
        chk($sformatf("edge%0d u%0d port %s", edge_no, i/2, (i%2 == 1) ? "b" : "a"),
            {rv_w[i], dout_w[i]}, {ev, held[i]});
    end
  endtask

  task automatic set_in(input logic ea, input logic [3:0] wa, input logic [6:0] aa, input logic [31:0] da,
                        input logic eb, input logic [3:0] wb, input logic [6:0] ab, input logic [31:0] db);
    ena = ea; wea = wa; addra = aa; dina = da;
    enb = eb; web = wb; addrb = ab; dinb = db;
  endtask

  task automatic idle();
    set_in(1'b0, 4'h0, 7'd0, 32'h0, 1'b0, 4'h0, 7'd0, 32'h0);
  endtask

  // Inputs are stable since the previous falling edge; outputs sampled 1ns after the rising edge
  task automatic step();
    model_edge();
    @(posedge clk);
    #1;
    check_outputs();
    @(negedge clk);
  endtask

  task automatic drain();
    idle();
    repeat (5) step();
  endtask

  function automatic logic [3:0] pick_we();
    case ($urandom_range(0, 3))
      0, 1: return 4'h0;
      2: return 4'hF;
      default: return 4'($urandom);
    endcase
  endfunction

  typedef struct {
    logic ea; logic [3:0] wa; logic [6:0] aa; logic [31:0] da;
    logic eb; logic [3:0] wb; logic [6:0] ab; logic [31:0] db;
    logic [31:0] x0a, x0b, x1a, x1b;  // held douta/doutb of u0 (RL2 WM0 CF1) and u1 (RL1 WM1 CF0)
  } vec_t;
  vec_t tbl [10];

  initial begin
    for (int i = 0; i < 128; i++) mem[i] = 32'h0;
    model_reset();

    tbl[0] = '{1'b1, 4'hF, 7'd3,  32'h11223344, 1'b0, 4'h0, 7'd0,  32'h0,
               32'h0,        32'h0,        32'h11223344, 32'h0};
    tbl[1] = '{1'b0, 4'h0, 7'd0,  32'h0,        1'b1, 4'h5, 7'd3,  32'hAABBCCDD,
               32'h0,        32'h11223344, 32'h11223344, 32'h11BB33DD};
    tbl[2] = '{1'b1, 4'h0, 7'd3,  32'h0,        1'b0, 4'h0, 7'd0,  32'h0,
               32'h11BB33DD, 32'h11223344, 32'h11BB33DD, 32'h11BB33DD};
    tbl[3] = '{1'b1, 4'hF, 7'd7,  32'h12345678, 1'b1, 4'h0, 7'd7,  32'h0,
               32'h0,        32'h12345678, 32'h12345678, 32'h0};
    tbl[4] = '{1'b1, 4'h0, 7'd7,  32'h0,        1'b1, 4'h0, 7'd7,  32'h0,
               32'h12345678, 32'h12345678, 32'h12345678, 32'h12345678};
    tbl[5] = '{1'b1, 4'h3, 7'd9,  32'hAAAAAAAA, 1'b1, 4'hE, 7'd9,  32'hBBBBBBBB,
               32'h0,        32'h0,        32'hBBBBAAAA, 32'hBBBBAAAA};
    tbl[6] = '{1'b1, 4'h3, 7'd10, 32'hAAAAAAAA, 1'b1, 4'h6, 7'd10, 32'hBBBBBBBB,
               32'h0,        32'h0,        32'h00BBAAAA, 32'h00BBAAAA};
    tbl[7] = '{1'b1, 4'h0, 7'd9,  32'h0,        1'b1, 4'h0, 7'd10, 32'h0,
               32'hBBBBAAAA, 32'h00BBAAAA, 32'hBBBBAAAA, 32'h00BBAAAA};
    tbl[8] = '{1'b1, 4'hF, 7'd5,  32'hDEADBEEF, 1'b0, 4'h0, 7'd0,  32'h0,
               32'h0,        32'h00BBAAAA, 32'hDEADBEEF, 32'h00BBAAAA};
    tbl[9] = '{1'b0, 4'h0, 7'd0,  32'h0,        1'b1, 4'h0, 7'd7,  32'h0,
               32'h0,        32'h12345678, 32'hDEADBEEF, 32'h12345678};

    // Reset values
    #2 rst = 1'b1;
    #1;
    for (int i = 0; i < NK*2; i++) chk($sformatf("reset u%0d out%0d", i/2, i%2), {rv_w[i], dout_w[i]}, 33'h0);
    @(negedge clk);
    rst = 1'b0;

    // Zero the array, then reset to flush the undefined old-word responses
    for (int i = 0; i < 128; i += 2) begin
      set_in(1'b1, 4'hF, 7'(i), 32'h0, 1'b1, 4'hF, 7'(i + 1), 32'h0);
      step();
    end
    drain();
    rst = 1'b1;
    model_reset();
    step();
    rst = 1'b0;
    chk_on = 1'b1;
    step();

    // Directed table
    for (int r = 0; r < 10; r++) begin
      set_in(tbl[r].ea, tbl[r].wa, tbl[r].aa, tbl[r].da, tbl[r].eb, tbl[r].wb, tbl[r].ab, tbl[r].db);
      step();
      drain();
      chk($sformatf("row%0d u0 douta", r), {1'b0, dout_w[0]}, {1'b0, tbl[r].x0a});
      chk($sformatf("row%0d u0 doutb", r), {1'b0, dout_w[1]}, {1'b0, tbl[r].x0b});
      chk($sformatf("row%0d u1 douta", r), {1'b0, dout_w[2]}, {1'b0, tbl[r].x1a});
      chk($sformatf("row%0d u1 doutb", r), {1'b0, dout_w[3]}, {1'b0, tbl[r].x1b});
    end

    // Latency on u0 (READ_LATENCY=2): read addr 5 on edge n
    set_in(1'b1, 4'h0, 7'd5, 32'h0, 1'b0, 4'h0, 7'd0, 32'h0);
    step();
    chk("lat after edge n", {rv_w[0], dout_w[0]}, {1'b0, 32'h0});
    idle();
    step();
    chk("lat after edge n+1", {rv_w[0], dout_w[0]}, {1'b1, 32'hDEADBEEF});
    step();
    chk("lat after edge n+2", {rv_w[0], dout_w[0]}, {1'b0, 32'hDEADBEEF});
    drain();

    // no_change on u2 (WRITE_MODE=2, READ_LATENCY=3)
    set_in(1'b1, 4'hF, 7'd1, 32'h55, 1'b0, 4'h0, 7'd0, 32'h0);
    step();
    drain();
    set_in(1'b1, 4'h0, 7'd1, 32'h0, 1'b0, 4'h0, 7'd0, 32'h0);
    step();
    drain();
    chk("nochg read 55", {1'b0, dout_w[4]}, {1'b0, 32'h55});
    set_in(1'b1, 4'hF, 7'd1, 32'h66, 1'b0, 4'h0, 7'd0, 32'h0);
    step();
    chk("nochg write quiet", {rv_w[4], dout_w[4]}, {1'b0, 32'h55});
    idle();
    for (int c = 0; c < 5; c++) begin
      step();
      chk($sformatf("nochg write quiet c%0d", c), {rv_w[4], dout_w[4]}, {1'b0, 32'h55});
    end
    set_in(1'b1, 4'h0, 7'd1, 32'h0, 1'b0, 4'h0, 7'd0, 32'h0);
    step();
    drain();
    chk("nochg read 66", {1'b0, dout_w[4]}, {1'b0, 32'h66});

    // Reset with reads in flight
    set_in(1'b1, 4'h0, 7'd5, 32'h0, 1'b0, 4'h0, 7'd0, 32'h0);
    step();
    step();
    chk("rst pre u0", {rv_w[0], dout_w[0]}, {1'b1, 32'hDEADBEEF});
    rst = 1'b1;
    model_reset();
    #1;
    chk("rst imm u0", {rv_w[0], dout_w[0]}, 33'h0);
    chk("rst imm u3", {rv_w[6], dout_w[6]}, 33'h0);
    set_in(1'b1, 4'hF, 7'd5, 32'hFFFFFFFF, 1'b1, 4'h0, 7'd5, 32'h0);
    step();
    step();
    rst = 1'b0;
    idle();
    for (int c = 0; c < 6; c++) begin
      step();
      chk($sformatf("rst no resurrect c%0d", c), {31'h0, rv_w[0], 1'b0, rv_w[6]}, 33'h0);
    end
    set_in(1'b1, 4'h0, 7'd5, 32'h0, 1'b0, 4'h0, 7'd0, 32'h0);
    step();
    drain();
    chk("rst write ignored", {1'b0, dout_w[0]}, {1'b0, 32'hDEADBEEF});

    // Random traffic against the model, biased toward address collisions
    for (int n = 0; n < 600; n++) begin
      logic [6:0] aa, ab;
      aa = ($urandom_range(0, 7) == 0) ? 7'($urandom_range(0, 127)) : 7'($urandom_range(0, 7));
      ab = ($urandom_range(0, 7) == 0) ? 7'($urandom_range(0, 127)) : 7'($urandom_range(0, 7));
      set_in($urandom_range(0, 3) != 0, pick_we(), aa, $urandom,
             $urandom_range(0, 3) != 0, pick_we(), ab, $urandom);
      step();
    end
    drain();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
